// File: rtl/hba_burst_master_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hba_burst_master_pkg : shared FSM encoding and default HBA widths         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package hba_burst_master_pkg;

   localparam int HBA_DBUS_WIDTH        = 8;
   localparam int HBA_PERIPH_ADDR_WIDTH = 4;
   localparam int HBA_REG_ADDR_WIDTH    = 8;
   localparam int HBA_MAX_LEN_WIDTH     = 4;
   localparam int HBA_TIMEOUT_CYCLES    = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_XFER = 2'd2,
      ST_GAP  = 2'd3
   } hba_state_e;

endpackage
`default_nettype wire

// File: rtl/hba_xfer_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hba_xfer_timer : saturating select-phase timer flagging a missing ack     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hba_xfer_timer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_MAX  = c_CNT_W'(TIMEOUT_CYCLES);
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

   logic [c_CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != c_MAX)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Count k marks the (k+1)-th select cycle, so expiry flags the last permitted one.
   assign expired_o = en_i && (cnt_q >= c_LAST);

endmodule
`default_nettype wire

// File: rtl/hba_burst_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hba_burst_master : HBA initiator running single writes / burst reads      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hba_burst_master
   import hba_burst_master_pkg::*;
#(
   parameter int DBUS_WIDTH        = HBA_DBUS_WIDTH,
   parameter int PERIPH_ADDR_WIDTH = HBA_PERIPH_ADDR_WIDTH,
   parameter int REG_ADDR_WIDTH    = HBA_REG_ADDR_WIDTH,
   parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
   parameter int MAX_LEN_WIDTH     = HBA_MAX_LEN_WIDTH,
   parameter int TIMEOUT_CYCLES    = HBA_TIMEOUT_CYCLES
) (
   input  logic                     hba_clk,
   input  logic                     hba_reset,
   input  logic                     hba_mgrant,
   input  logic                     hba_xferack,
   input  logic [DBUS_WIDTH-1:0]    hba_dbus,
   output logic                     hba_mreq,
   output logic                     hba_select_master,
   output logic                     hba_rnw_master,
   output logic [ADDR_WIDTH-1:0]    hba_abus_master,
   output logic [DBUS_WIDTH-1:0]    hba_dbus_master,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_rnw,
   input  logic [ADDR_WIDTH-1:0]    cmd_addr,
   input  logic [DBUS_WIDTH-1:0]    cmd_wdata,
   input  logic [MAX_LEN_WIDTH-1:0] cmd_len,
   output logic                     rsp_valid,
   output logic [DBUS_WIDTH-1:0]    rsp_rdata,
   output logic                     rsp_err,
   output logic                     rsp_last
);

   localparam logic [MAX_LEN_WIDTH:0] c_FULL_BURST = {1'b1, {MAX_LEN_WIDTH{1'b0}}};
   localparam logic [MAX_LEN_WIDTH:0] c_ONE_BEAT   = {{MAX_LEN_WIDTH{1'b0}}, 1'b1};

   hba_state_e              state_q;
   logic                    cur_rnw_q;
   logic [ADDR_WIDTH-1:0]   cur_addr_q;
   logic [DBUS_WIDTH-1:0]   wdata_q;
   logic [MAX_LEN_WIDTH:0]  beats_q;
   logic                    mreq_q;
   logic                    select_q;
   logic                    rnw_bus_q;
   logic [ADDR_WIDTH-1:0]   abus_q;
   logic [DBUS_WIDTH-1:0]   dbus_out_q;
   logic                    rsp_valid_q;
   logic [DBUS_WIDTH-1:0]   rsp_rdata_q;
   logic                    rsp_err_q;
   logic                    rsp_last_q;

   logic [ADDR_WIDTH-1:0]   addr_inc_d;
   logic [MAX_LEN_WIDTH:0]  beats_init_d;
   logic [DBUS_WIDTH-1:0]   beat_wdata_d;
   logic                    timer_expired_d;

   // Only the register field advances; the peripheral field stays fixed.
   assign addr_inc_d   = {cur_addr_q[ADDR_WIDTH-1:REG_ADDR_WIDTH],
                          cur_addr_q[REG_ADDR_WIDTH-1:0] + 1'b1};
   assign beats_init_d = !cmd_rnw          ? c_ONE_BEAT   :
                         (cmd_len == '0)   ? c_FULL_BURST : {1'b0, cmd_len};
   assign beat_wdata_d = cur_rnw_q ? '0 : wdata_q;

   hba_xfer_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk       (hba_clk),
      .rst       (hba_reset),
      .clear_i   (state_q != ST_XFER),
      .en_i      (state_q == ST_XFER),
      .expired_o (timer_expired_d)
   );

   always_ff @(posedge hba_clk or posedge hba_reset) begin
      if (hba_reset) begin
         state_q     <= ST_IDLE;
         cur_rnw_q   <= 1'b0;
         cur_addr_q  <= '0;
         wdata_q     <= '0;
         beats_q     <= '0;
         mreq_q      <= 1'b0;
         select_q    <= 1'b0;
         rnw_bus_q   <= 1'b0;
         abus_q      <= '0;
         dbus_out_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_last_q  <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_last_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  cur_rnw_q  <= cmd_rnw;
                  cur_addr_q <= cmd_addr;
                  wdata_q    <= cmd_wdata;
                  beats_q    <= beats_init_d;
                  mreq_q     <= 1'b1;
                  state_q    <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (hba_mgrant) begin
                  select_q   <= 1'b1;
                  rnw_bus_q  <= cur_rnw_q;
                  abus_q     <= cur_addr_q;
                  dbus_out_q <= beat_wdata_d;
                  state_q    <= ST_XFER;
               end
            end
            ST_XFER: begin
               // An ack landing on the expiry cycle still completes the beat cleanly.
               if (hba_xferack) begin
                  select_q    <= 1'b0;
                  rnw_bus_q   <= 1'b0;
                  abus_q      <= '0;
                  dbus_out_q  <= '0;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= cur_rnw_q ? hba_dbus : '0;
                  rsp_last_q  <= (beats_q == c_ONE_BEAT);
                  beats_q     <= beats_q - c_ONE_BEAT;
                  cur_addr_q  <= addr_inc_d;
                  state_q     <= ST_GAP;
               end else if (timer_expired_d) begin
                  select_q    <= 1'b0;
                  rnw_bus_q   <= 1'b0;
                  abus_q      <= '0;
                  dbus_out_q  <= '0;
                  mreq_q      <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_last_q  <= 1'b1;
                  beats_q     <= '0;
                  state_q     <= ST_IDLE;
               end
            end
            ST_GAP: begin
               if (beats_q != '0) begin
                  if (hba_mgrant) begin
                     select_q   <= 1'b1;
                     rnw_bus_q  <= cur_rnw_q;
                     abus_q     <= cur_addr_q;
                     dbus_out_q <= beat_wdata_d;
                     state_q    <= ST_XFER;
                  end else begin
                     state_q    <= ST_REQ;
                  end
               end else begin
                  mreq_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready         = (state_q == ST_IDLE);
   assign hba_mreq          = mreq_q;
   assign hba_select_master = select_q;
   assign hba_rnw_master    = rnw_bus_q;
   assign hba_abus_master   = abus_q;
   assign hba_dbus_master   = dbus_out_q;
   assign rsp_valid         = rsp_valid_q;
   assign rsp_rdata         = rsp_rdata_q;
   assign rsp_err           = rsp_err_q;
   assign rsp_last          = rsp_last_q;

endmodule
`default_nettype wire

// File: tb/tb_hba_burst_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hba_burst_master : directed + randomized bench with a slave model      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_hba_burst_master;

   localparam int TMO = 8;

   logic        hba_clk    = 1'b0;
   logic        hba_reset  = 1'b1;
   logic        hba_mgrant = 1'b0;
   logic        hba_xferack;
   logic [7:0]  hba_dbus;
   logic        hba_mreq, hba_select_master, hba_rnw_master;
   logic [11:0] hba_abus_master;
   logic [7:0]  hba_dbus_master;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_rnw   = 1'b0;
   logic [11:0] cmd_addr  = '0;
   logic [7:0]  cmd_wdata = '0;
   logic [3:0]  cmd_len   = '0;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err, rsp_last;

   hba_burst_master #(
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .hba_clk           (hba_clk),
      .hba_reset         (hba_reset),
      .hba_mgrant        (hba_mgrant),
      .hba_xferack       (hba_xferack),
      .hba_dbus          (hba_dbus),
      .hba_mreq          (hba_mreq),
      .hba_select_master (hba_select_master),
      .hba_rnw_master    (hba_rnw_master),
      .hba_abus_master   (hba_abus_master),
      .hba_dbus_master   (hba_dbus_master),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .cmd_rnw           (cmd_rnw),
      .cmd_addr          (cmd_addr),
      .cmd_wdata         (cmd_wdata),
      .cmd_len           (cmd_len),
      .rsp_valid         (rsp_valid),
      .rsp_rdata         (rsp_rdata),
      .rsp_err           (rsp_err),
      .rsp_last          (rsp_last)
   );

   always #5 hba_clk = ~hba_clk;

   int cyc = 0;
   always @(posedge hba_clk) cyc <= cyc + 1;

   // Slave: acks after ack_delay select cycles, returns reg index XOR key.
   int         ack_delay = 1;
   logic [7:0] key       = 8'h00;
   bit         stray_en  = 1'b0;
   int         sel_cnt   = 0;
   logic       stray_q   = 1'b0;

   always @(posedge hba_clk) begin
      sel_cnt <= hba_select_master ? sel_cnt + 1 : 0;
      stray_q <= stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   assign hba_xferack = (hba_select_master && (sel_cnt == ack_delay)) ||
                        (!hba_select_master && stray_q);
   assign hba_dbus    = !hba_xferack      ? 8'h00 :
                        hba_select_master ? (hba_abus_master[7:0] ^ key) : 8'hFF;

   typedef struct {
      int          rise;
      int          len;
      logic [11:0] addr;
      logic        rnw;
      logic [7:0]  dbus;
   } beat_t;

   typedef struct {
      int         cyc;
      logic [7:0] rdata;
      logic       err;
      logic       last;
      logic       mreq;
      logic       ready;
   } rsp_t;

   beat_t beats[$];
   rsp_t  rsps[$];
   beat_t mon_b;
   logic  prev_sel    = 1'b0;
   logic  prev_grant  = 1'b0;
   int    bus_idle_bad = 0;
   int    sel_nogrant  = 0;

   always @(negedge hba_clk) begin
      if (hba_select_master) begin
         if (!prev_sel) begin
            mon_b.rise = cyc;
            mon_b.len  = 1;
            mon_b.addr = hba_abus_master;
            mon_b.rnw  = hba_rnw_master;
            mon_b.dbus = hba_dbus_master;
            if (!prev_grant) sel_nogrant++;
            beats.push_back(mon_b);
         end else if (beats.size() > 0) begin
            mon_b = beats[beats.size()-1];
            mon_b.len = mon_b.len + 1;
            beats[beats.size()-1] = mon_b;
         end
      end else if (hba_rnw_master || (hba_abus_master != '0) || (hba_dbus_master != '0)) begin
         bus_idle_bad++;
      end
      if (rsp_valid)
         rsps.push_back('{cyc, rsp_rdata, rsp_err, rsp_last, hba_mreq, cmd_ready});
      prev_sel   = hba_select_master;
      prev_grant = hba_mgrant;
   end

   int nvec  = 0;
   int nfail = 0;
   int acc_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: beats a command should produce given the slave's ack delay.
   function automatic int exp_beats(input logic rnw, input logic [3:0] len);
      if (ack_delay >= TMO) return 1;
      if (!rnw) return 1;
      return (len == 4'd0) ? 16 : int'(len);
   endfunction

   task automatic issue(input logic rnw, input logic [11:0] addr, input logic [7:0] wd,
                        input logic [3:0] len, input bit junk);
      beats.delete();
      rsps.delete();
      @(posedge hba_clk); #1;
      cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wd; cmd_len = len;
      acc_cyc = cyc;
      chk("cmd_ready_idle", cmd_ready, 1);
      @(posedge hba_clk); #1;
      cmd_valid = junk;
      if (junk) begin
         cmd_rnw = 1'($urandom); cmd_addr = 12'($urandom);
         cmd_wdata = 8'($urandom); cmd_len = 4'($urandom);
      end
      chk("cmd_ready_busy", cmd_ready, 0);
   endtask

   task automatic wait_done(input int nexp);
      int t;
      t = 0;
      while ((rsps.size() < nexp) && (t < 600)) begin
         @(negedge hba_clk); #1;
         t++;
      end
      cmd_valid = 1'b0;
      chk("done_within_budget", (t < 600), 1);
      repeat (4) @(posedge hba_clk);
      #1;
      chk("idle_select", hba_select_master, 0);
      chk("idle_mreq", hba_mreq, 0);
      chk("idle_ready", cmd_ready, 1);
   endtask

   task automatic check_cmd(input logic rnw, input logic [11:0] addr, input logic [7:0] wd,
                            input logic [3:0] len, input bit timing);
      int n;
      bit to;
      logic [11:0] ea;
      to = (ack_delay >= TMO);
      n  = exp_beats(rnw, len);
      chk("beats_issued", beats.size(), n);
      chk("rsp_count", rsps.size(), n);
      for (int i = 0; i < n; i++) begin
         if ((i >= beats.size()) || (i >= rsps.size())) break;
         ea = {addr[11:8], 8'(addr[7:0] + 8'(i))};
         chk($sformatf("abus[%0d]", i), beats[i].addr, ea);
         chk($sformatf("rnw[%0d]", i), beats[i].rnw, rnw);
         chk($sformatf("dbus_m[%0d]", i), beats[i].dbus, rnw ? 8'h00 : wd);
         chk($sformatf("sel_len[%0d]", i), beats[i].len, to ? TMO : ack_delay + 1);
         chk($sformatf("rdata[%0d]", i), rsps[i].rdata,
             (to || !rnw) ? 8'h00 : (ea[7:0] ^ key));
         chk($sformatf("err[%0d]", i), rsps[i].err, to);
         chk($sformatf("last[%0d]", i), rsps[i].last, (i == n - 1));
         chk($sformatf("rsp_cyc[%0d]", i), rsps[i].cyc, beats[i].rise + beats[i].len);
         if (to) begin
            chk("abort_mreq", rsps[i].mreq, 0);
            chk("abort_ready", rsps[i].ready, 1);
         end
         if (timing) begin
            if (i == 0)
               chk("accept_to_select", beats[0].rise - acc_cyc, 2);
            else
               chk($sformatf("gap[%0d]", i),
                   beats[i].rise - (beats[i-1].rise + beats[i-1].len), 1);
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic        r_rnw;
      logic [11:0] r_addr;
      logic [7:0]  r_wd;
      logic [3:0]  r_len;
      int          t;

      // Reset state
      repeat (3) @(posedge hba_clk);
      #1;
      chk("rst_select", hba_select_master, 0);
      chk("rst_mreq", hba_mreq, 0);
      chk("rst_abus", hba_abus_master, 0);
      chk("rst_dbus", hba_dbus_master, 0);
      chk("rst_rnw", hba_rnw_master, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_flags", {rsp_err, rsp_last, rsp_rdata}, 0);
      hba_reset = 1'b0;
      chk("rst_ready", cmd_ready, 1);

      // Single write, grant tied high
      hba_mgrant = 1'b1; ack_delay = 1; key = 8'h00;
      issue(1'b0, 12'h203, 8'hA5, 4'd0, 1'b0);
      wait_done(exp_beats(1'b0, 4'd0));
      check_cmd(1'b0, 12'h203, 8'hA5, 4'd0, 1'b1);

      // Burst read wrapping within the peripheral
      issue(1'b1, 12'h1FE, 8'h00, 4'd4, 1'b0);
      wait_done(exp_beats(1'b1, 4'd4));
      check_cmd(1'b1, 12'h1FE, 8'h00, 4'd4, 1'b1);

      // Delayed grant, revoked during the gap after beat 1
      hba_mgrant = 1'b0; key = 8'($urandom);
      issue(1'b1, 12'h5F0, 8'h00, 4'd3, 1'b0);
      repeat (5) @(posedge hba_clk);
      #1;
      chk("t3_mreq_waiting", hba_mreq, 1);
      chk("t3_no_select_waiting", hba_select_master, 0);
      hba_mgrant = 1'b1;
      t = 0;
      while ((rsps.size() < 1) && (t < 100)) begin
         @(negedge hba_clk); #1;
         t++;
      end
      hba_mgrant = 1'b0;
      repeat (4) @(posedge hba_clk);
      #1;
      chk("t3_mreq_held", hba_mreq, 1);
      chk("t3_select_low", hba_select_master, 0);
      chk("t3_beats_before_regrant", beats.size(), 1);
      hba_mgrant = 1'b1;
      wait_done(exp_beats(1'b1, 4'd3));
      check_cmd(1'b1, 12'h5F0, 8'h00, 4'd3, 1'b0);
      chk("select_without_grant", sel_nogrant, 0);

      // Silent slave: timeout aborts the burst
      ack_delay = 20;
      issue(1'b1, 12'h3A0, 8'h00, 4'd3, 1'b0);
      wait_done(exp_beats(1'b1, 4'd3));
      check_cmd(1'b1, 12'h3A0, 8'h00, 4'd3, 1'b1);

      // Async reset in the middle of a beat
      ack_delay = 3;
      issue(1'b1, 12'h740, 8'h00, 4'd4, 1'b0);
      t = 0;
      while (!hba_select_master && (t < 50)) begin
         @(negedge hba_clk);
         t++;
      end
      @(posedge hba_clk); #2;
      chk("t5_select_before_reset", hba_select_master, 1);
      hba_reset = 1'b1;
      #1;
      chk("t5_select_async", hba_select_master, 0);
      chk("t5_mreq_async", hba_mreq, 0);
      chk("t5_abus_async", hba_abus_master, 0);
      beats.delete();
      rsps.delete();
      @(negedge hba_clk); #1;
      hba_reset = 1'b0;
      repeat (3) @(posedge hba_clk);
      #1;
      chk("t5_ready_after", cmd_ready, 1);
      chk("t5_no_rsp", rsps.size(), 0);
      chk("t5_no_beats", beats.size(), 0);
      ack_delay = 0; key = 8'($urandom);
      issue(1'b1, 12'h7FF, 8'h00, 4'd2, 1'b0);
      wait_done(exp_beats(1'b1, 4'd2));
      check_cmd(1'b1, 12'h7FF, 8'h00, 4'd2, 1'b1);

      // Max-length burst, ack on the expiry cycle of every beat
      ack_delay = TMO - 1; key = 8'($urandom);
      issue(1'b1, 12'h9F8, 8'h00, 4'd0, 1'b0);
      wait_done(exp_beats(1'b1, 4'd0));
      check_cmd(1'b1, 12'h9F8, 8'h00, 4'd0, 1'b1);

      // Randomized commands with stray acks and junk commands while busy
      stray_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         ack_delay = ($urandom_range(0, 9) == 9) ? 12 : int'($urandom_range(0, 3));
         key    = 8'($urandom);
         r_rnw  = 1'($urandom);
         r_addr = 12'($urandom);
         r_wd   = 8'($urandom);
         r_len  = 4'($urandom);
         issue(r_rnw, r_addr, r_wd, r_len, 1'b1);
         wait_done(exp_beats(r_rnw, r_len));
         check_cmd(r_rnw, r_addr, r_wd, r_len, 1'b1);
      end
      stray_en = 1'b0;

      chk("bus_zero_outside_xfer", bus_idle_bad, 0);
      chk("select_without_grant_final", sel_nogrant, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
`default_nettype wire
